// File: rtl/score_pkg.sv
// ------------------------------------------------------------------
// score_pkg : shared font ROM, converter state type and saturation helper
// Revision  : 1.0
// ------------------------------------------------------------------
`default_nettype none

package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  // 8x16 glyphs for '0'..'9'; bit [7-col] is column col, 0 = lit pixel
  localparam logic [7:0] DIGIT_FONT [10][16] = '{
    '{8'hFF, 8'hFF, 8'hC3, 8'h99, 8'h99, 8'h91, 8'h89, 8'h99, 8'h99, 8'h99, 8'h99, 8'hC3, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'hE7, 8'hC7, 8'hE7, 8'hE7, 8'hE7, 8'hE7, 8'hE7, 8'hE7, 8'hE7, 8'h81, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'hC3, 8'h99, 8'hF9, 8'hF9, 8'hF3, 8'hE7, 8'hCF, 8'h9F, 8'h99, 8'h81, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'hC3, 8'h99, 8'hF9, 8'hF9, 8'hE3, 8'hF9, 8'hF9, 8'hF9, 8'h99, 8'hC3, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'hF3, 8'hE3, 8'hC3, 8'h93, 8'h33, 8'h01, 8'hF3, 8'hF3, 8'hF3, 8'hE1, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'h81, 8'h9F, 8'h9F, 8'h9F, 8'h83, 8'hF9, 8'hF9, 8'hF9, 8'h99, 8'hC3, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'hE3, 8'hCF, 8'h9F, 8'h9F, 8'h83, 8'h99, 8'h99, 8'h99, 8'h99, 8'hC3, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'h81, 8'h99, 8'hF9, 8'hF9, 8'hF3, 8'hE7, 8'hE7, 8'hE7, 8'hE7, 8'hE7, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'hC3, 8'h99, 8'h99, 8'h99, 8'hC3, 8'h99, 8'h99, 8'h99, 8'h99, 8'hC3, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'hC3, 8'h99, 8'h99, 8'h99, 8'hC1, 8'hF9, 8'hF9, 8'hF9, 8'hF3, 8'hC7, 8'hFF, 8'hFF, 8'hFF, 8'hFF}
  };

  // Clamp to the largest value representable in ndigits decimal digits (ndigits <= 8)
  function automatic logic [31:0] sat_dec(input logic [31:0] value, input int ndigits);
    logic [31:0] lim;
    lim = 32'd1;
    for (int i = 0; i < 8; i++) begin
      if (i < ndigits) lim = lim * 32'd10;
    end
    lim = lim - 32'd1;
    return (value > lim) ? lim : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ------------------------------------------------------------------
// bin2bcd_seq : iterative double-dabble converter, one bit per clock
// Revision    : 1.0
// ------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      value_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  conv_state_t                state_q;
  logic [BIN_W-1:0]           bin_q;
  logic [4*DIGITS-1:0]        bcd_q;
  logic [CNT_W-1:0]           cnt_q;

  logic [4*DIGITS-1:0]        adj_bcd;
  logic [4*DIGITS+BIN_W-1:0]  shifted;
  logic [4*DIGITS-1:0]        bcd_d;
  logic [BIN_W-1:0]           bin_d;

  always_comb begin
    adj_bcd = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj_bcd[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    shifted = {adj_bcd, bin_q} << 1;
    bcd_d   = shifted[4*DIGITS+BIN_W-1:BIN_W];
    bin_d   = shifted[BIN_W-1:0];
  end

  // Caller guarantees the loaded value fits in DIGITS decimal digits
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            bin_q   <= value_i;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(BIN_W - 1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          if (cnt_q == '0) state_q <= LATCH;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        LATCH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == LATCH);
  assign bcd_o  = bcd_q;

endmodule

`default_nettype wire

// File: rtl/score_display_bcd.sv
// ------------------------------------------------------------------
// score_display_bcd : session high score tracker with blinking BCD readout
// Revision          : 1.0
// ------------------------------------------------------------------
`default_nettype none

module score_display_bcd
  import score_pkg::*;
#(
  parameter int         NUM_DIGITS   = 6,
  parameter int         SCORE_W      = 20,
  parameter logic [7:0] DIGIT_COLOR  = 8'hFF,
  parameter int         BLINK_FRAMES = 16,
  parameter bit         LZ_BLANK     = 1'b1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startGame,
  input  logic [10:0]        offsetX,
  input  logic [10:0]        offsetY,
  input  logic               insideRectangle,
  input  logic [SCORE_W-1:0] score,
  output logic               drawingRequest,
  output logic [7:0]         RGBout,
  output logic [SCORE_W-1:0] highScore,
  output logic               newHighScore,
  output logic               convBusy
);

  localparam int         BLINK_W      = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0] c_NUM_DIGITS = 8'(NUM_DIGITS);

  logic [SCORE_W-1:0]          highScore_q;
  logic                        newHigh_q;
  logic [BLINK_W-1:0]          blink_q;
  logic [NUM_DIGITS-1:0][3:0]  digit_q;
  logic                        draw_q;
  logic                        draw_d;

  logic [4*NUM_DIGITS-1:0]     conv_bcd;
  logic                        conv_done;
  logic                        conv_busy;

  logic [NUM_DIGITS-1:0]       blank;
  logic                        lz_run;
  logic [7:0]                  d_idx;
  logic [3:0]                  sel_digit;
  logic                        sel_blank;
  logic [7:0]                  glyph_row;
  logic                        font_lit;
  logic                        blink_off;

  // startGame wins over a coincident new record for the flag only
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      highScore_q <= '0;
      newHigh_q   <= 1'b0;
    end else begin
      if (score > highScore_q) highScore_q <= score;
      if (startGame)                newHigh_q <= 1'b0;
      else if (score > highScore_q) newHigh_q <= 1'b1;
    end
  end

  bin2bcd_seq #(
    .BIN_W  (SCORE_W),
    .DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .resetN  (resetN),
    .start_i (startOfFrame),
    .value_i (SCORE_W'(sat_dec(32'(highScore_q), NUM_DIGITS))),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // digit_q[0] is the leftmost, most significant digit
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digit_q <= '0;
    end else if (conv_done) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digit_q[k] <= conv_bcd[4*(NUM_DIGITS-1-k) +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)           blink_q <= '0;
    else if (!newHigh_q)   blink_q <= '0;
    else if (startOfFrame) blink_q <= blink_q + BLINK_W'(1);
  end

  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lz_run   = lz_run && (digit_q[k] == 4'd0);
      blank[k] = LZ_BLANK && lz_run && (k != NUM_DIGITS - 1);
    end
  end

  assign d_idx = offsetX[10:3];

  always_comb begin
    sel_digit = 4'd0;
    sel_blank = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (d_idx == 8'(k)) begin
        sel_digit = digit_q[k];
        sel_blank = blank[k];
      end
    end
  end

  assign glyph_row = (sel_digit <= 4'd9) ? DIGIT_FONT[sel_digit][offsetY[3:0]] : 8'hFF;
  assign font_lit  = ~glyph_row[3'd7 - offsetX[2:0]];
  assign blink_off = newHigh_q && blink_q[BLINK_W-1];

  assign draw_d = insideRectangle && (d_idx < c_NUM_DIGITS) && (offsetY[10:4] == 7'd0) &&
                  !sel_blank && !blink_off && font_lit;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) draw_q <= 1'b0;
    else         draw_q <= draw_d;
  end

  assign drawingRequest = draw_q;
  assign RGBout         = DIGIT_COLOR;
  assign highScore      = highScore_q;
  assign newHighScore   = newHigh_q;
  assign convBusy       = conv_busy;

endmodule

`default_nettype wire
